// File: rtl/alu_4bit.sv
// alu_4bit: 4-bit registered ALU (execute stage), 8 ops, result plus Z/C/S flags.
// Ports: clk, reset (async high), en, A, B, cin, Op in; R, z, c, s registered out.
module alu_4bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    input  logic [2:0] Op,
    output logic [3:0] R,
    output logic       z,
    output logic       c,
    output logic       s
);

    logic [4:0] sum;
    logic [4:0] a_x;
    logic [4:0] b_x;
    logic [4:0] ci_x;
    logic [3:0] r_d;
    logic       z_d;
    logic       c_d;
    logic       s_d;
    logic [3:0] r_q;
    logic       z_q;
    logic       c_q;
    logic       s_q;

    assign a_x  = {1'b0, A};
    assign b_x  = {1'b0, B};
    assign ci_x = {4'b0000, cin};

    always_comb begin
        sum = 5'd0;
        r_d = 4'd0;
        c_d = 1'b0;
        unique case (Op)
            3'b000: sum = a_x + ci_x;
            // Negate: zero-extend ~A before adding, so carry-out only
            // appears when ~A is all ones (A=0) or A=1 with cin.
            3'b001: sum = {1'b0, ~A} + 5'd1 + ci_x;
            3'b010: sum = a_x + b_x + ci_x;
            3'b011: sum = a_x + 5'd1 + ci_x;
            3'b100: sum = {1'b0, A & B};
            3'b101: sum = {1'b0, A | B};
            3'b110: sum = {1'b0, A ^ B};
            3'b111: sum = {1'b0, ~A};
            default: sum = 5'd0;
        endcase
        r_d = sum[3:0];
        // Logical ops never produce a carry.
        c_d = Op[2] ? 1'b0 : sum[4];
        z_d = (r_d == 4'd0);
        s_d = r_d[3];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 4'd0;
            z_q <= 1'b1;
            c_q <= 1'b0;
            s_q <= 1'b0;
        end else if (en) begin
            r_q <= r_d;
            z_q <= z_d;
            c_q <= c_d;
            s_q <= s_d;
        end
    end

    assign R = r_q;
    assign z = z_q;
    assign c = c_q;
    assign s = s_q;

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed and exhaustive checks of alu_4bit against an
// integer reference model, using an expected-value queue.
module tb_alu_4bit;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [2:0] Op;
    logic [3:0] R;
    logic       z;
    logic       c;
    logic       s;

    int n_checks;
    int n_fail;
    logic [6:0] exp_q[$];
    logic [6:0] last_exp;

    alu_4bit dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .Op   (Op),
        .R    (R),
        .z    (z),
        .c    (c),
        .s    (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, packed as {R, z, c, s}.
    function automatic logic [6:0] model(input int op, input int a,
                                         input int b, input int ci);
        int v;
        int r;
        int cy;
        v  = 0;
        cy = 0;
        case (op)
            0: v = a + ci;
            1: v = (15 - a) + 1 + ci;
            2: v = a + b + ci;
            3: v = a + 1 + ci;
            4: v = a & b;
            5: v = a | b;
            6: v = a ^ b;
            default: v = 15 - a;
        endcase
        r = v % 16;
        if (op < 4) cy = (v >= 16) ? 1 : 0;
        return {r[3:0], (r == 0), cy[0], r[3]};
    endfunction

    task automatic check(input string tag, input logic [6:0] exp);
        n_checks++;
        assert ({R, z, c, s} === exp) else begin
            n_fail++;
            $error("FAIL %s: got R/z/c/s=%b expected %b",
                   tag, {R, z, c, s}, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, got %b expected entry",
                   tag, {R, z, c, s});
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check(tag, e);
        end
    endtask

    // Drive one operation with en=1, then compare one cycle later.
    task automatic step(input string tag, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic ci);
        Op  = op;
        A   = a;
        B   = b;
        cin = ci;
        en  = 1'b1;
        exp_q.push_back(model(int'(op), int'(a), int'(b), int'(ci)));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = 7'b0000_100;
        reset = 1'b1;
        en    = 1'b1;
        A     = 4'hF;
        B     = 4'hF;
        cin   = 1'b1;
        Op    = 3'b010;
        #2;
        check("reset_initial", 7'b0000_100);
        @(posedge clk);
        #1;
        check("reset_hold_en1", 7'b0000_100);
        reset = 1'b0;

        step("add_wrap", 3'b010, 4'b1111, 4'b0001, 1'b0);
        check("add_wrap_const", 7'b0000_110);
        step("add_cin", 3'b010, 4'b0111, 4'b0000, 1'b1);
        check("add_cin_const", 7'b1000_001);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 7'b0000_100);
        A   = 4'h9;
        Op  = 3'b101;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("reset_overrides_en", 7'b0000_100);
        reset = 1'b0;

        step("neg_zero", 3'b001, 4'b0000, 4'b1010, 1'b0);
        check("neg_zero_const", 7'b0000_110);
        step("neg_three", 3'b001, 4'b0011, 4'b0000, 1'b0);
        check("neg_three_const", 7'b1101_001);
        step("neg_one_cin", 3'b001, 4'b0001, 4'b0000, 1'b1);
        check("neg_one_cin_const", 7'b0000_110);
        step("inc_wrap", 3'b011, 4'b1110, 4'b0101, 1'b1);
        check("inc_wrap_const", 7'b0000_110);
        step("pass_wrap", 3'b000, 4'b1111, 4'b0011, 1'b1);
        check("pass_wrap_const", 7'b0000_110);
        step("and", 3'b100, 4'b1010, 4'b0110, 1'b1);
        check("and_const", 7'b0010_000);
        step("or", 3'b101, 4'b1010, 4'b0110, 1'b1);
        check("or_const", 7'b1110_001);
        step("xor", 3'b110, 4'b1010, 4'b0110, 1'b1);
        check("xor_const", 7'b1100_001);
        step("not", 3'b111, 4'b1010, 4'b0110, 1'b1);
        check("not_const", 7'b0101_000);

        // Hold with en=0 while inputs change.
        en  = 1'b0;
        Op  = 3'b010;
        A   = 4'hF;
        B   = 4'hF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        check("hold_1", last_exp);
        Op = 3'b001;
        A  = 4'h0;
        @(posedge clk);
        #1;
        check("hold_2", last_exp);

        // Exhaustive sweep.
        for (int op = 0; op < 8; op++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        step("sweep", op[2:0], a[3:0], b[3:0], ci[0]);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
